// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver with a runtime baud divisor.
//            Supports 5..9 data bits, optional even/odd parity and one or
//            two stop bits. Each frame is stored in a small FIFO together
//            with its parity and stop-bit error flags, and is presented to
//            the consumer through a valid/ready handshake.
// Ports    : i_Clock, i_Reset       - clock, asynchronous active-high reset
//            i_Clks_Per_Bit         - bit period in clocks (values < 4 act as 4)
//            i_Parity_En/Odd        - parity present / odd (1) or even (0)
//            i_Two_Stop             - two stop bits when 1
//            i_Rx_Serial            - asynchronous serial input, idle high
//            o_Rx_Valid/i_Rx_Ready  - FIFO head handshake
//            o_Rx_Data, o_Parity_Err, o_Frame_Err - head entry, 0 when empty
//            o_Overrun              - one-cycle pulse when a frame is dropped
//            o_Busy                 - receiver FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [DIV_WIDTH-1:0]  i_Clks_Per_Bit,
    input  logic                  i_Parity_En,
    input  logic                  i_Parity_Odd,
    input  logic                  i_Two_Stop,
    input  logic                  i_Rx_Serial,
    output logic                  o_Rx_Valid,
    input  logic                  i_Rx_Ready,
    output logic [DATA_WIDTH-1:0] o_Rx_Data,
    output logic                  o_Parity_Err,
    output logic                  o_Frame_Err,
    output logic                  o_Overrun,
    output logic                  o_Busy
);

    localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int c_IDX_W   = $clog2(DATA_WIDTH);
    localparam int c_ENTRY_W = DATA_WIDTH + 2;

    localparam logic [DIV_WIDTH-1:0] c_MIN_DIV  = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] c_DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_IDX_W-1:0]   c_LAST_BIT = c_IDX_W'(DATA_WIDTH - 1);
    localparam logic [c_ADDR_W:0]    c_PTR_ONE  = (c_ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP1     = 3'd4,
        S_STOP2     = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (idle-high reset value avoids a phantom start)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_par_en;
    logic                  r_par_odd;
    logic                  r_two_stop;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_parity_err;
    logic                  r_frame_err;

    logic [DIV_WIDTH-1:0]  w_div_eff;
    logic                  w_half_bit;
    logic                  w_bit_end;
    logic                  w_push;
    logic                  w_push_ferr;
    logic [c_ENTRY_W-1:0]  w_entry;

    assign w_div_eff  = (i_Clks_Per_Bit < c_MIN_DIV) ? c_MIN_DIV : i_Clks_Per_Bit;
    assign w_half_bit = (r_cnt == (r_div >> 1));
    assign w_bit_end  = (r_cnt == (r_div - c_DIV_ONE));

    // The final stop sample both pushes the frame and decides where to go
    // next. The error register is cleared at start-bit confirmation, so it
    // only carries a STOP1 error into the STOP2 decision.
    assign w_push      = w_bit_end &&
                         (((r_state == S_STOP1) && !r_two_stop) || (r_state == S_STOP2));
    assign w_push_ferr = r_frame_err | ~r_rx_s;
    assign w_entry     = {w_push_ferr, r_parity_err, r_data};

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_div        <= c_MIN_DIV;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_two_stop   <= 1'b0;
            r_idx        <= '0;
            r_data       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        // Frame format is frozen here for the whole frame.
                        r_state    <= S_START;
                        r_cnt      <= '0;
                        r_div      <= w_div_eff;
                        r_par_en   <= i_Parity_En;
                        r_par_odd  <= i_Parity_Odd;
                        r_two_stop <= i_Two_Stop;
                    end
                end

                S_START: begin
                    if (w_half_bit) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state      <= S_DATA;
                            r_idx        <= '0;
                            r_parity_err <= 1'b0;
                            r_frame_err  <= 1'b0;
                        end else begin
                            // Line went high again: glitch, not a start bit.
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt         <= '0;
                        r_data[r_idx] <= r_rx_s;
                        if (r_idx == c_LAST_BIT) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP1;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt        <= '0;
                        r_parity_err <= (^r_data) ^ r_rx_s ^ r_par_odd;
                        r_state      <= S_STOP1;
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end

                S_STOP1: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_two_stop) begin
                            r_frame_err <= ~r_rx_s;
                            r_state     <= S_STOP2;
                        end else begin
                            r_state <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end

                S_STOP2: begin
                    if (w_bit_end) begin
                        r_cnt       <= '0;
                        r_frame_err <= w_push_ferr;
                        r_state     <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + c_DIV_ONE;
                    end
                end

                S_WAIT_HIGH: begin
                    // A held-low line (break) must not look like new frames.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_ADDR_W:0]    r_wr_ptr;
    logic [c_ADDR_W:0]    r_rd_ptr;
    logic                 r_overrun;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_en;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_pop   = !w_empty && i_Rx_Ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_overrun <= w_push && w_full && !w_pop;
        end
    end

    // Storage needs no reset: every read is masked while the FIFO is empty.
    always_ff @(posedge i_Clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_entry;
        end
    end

    assign w_head       = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign o_Rx_Valid   = !w_empty;
    assign o_Rx_Data    = w_empty ? '0   : w_head[DATA_WIDTH-1:0];
    assign o_Parity_Err = w_empty ? 1'b0 : w_head[DATA_WIDTH];
    assign o_Frame_Err  = w_empty ? 1'b0 : w_head[DATA_WIDTH+1];
    assign o_Overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Self-checking bench for uart_rx_param. A second instance with
//            7 data bits, odd parity and two stop bits covers 7O2 framing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpb = 16'd16;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        two_stop = 1'b0;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        perr;
    logic        ferr;
    logic        overrun;
    logic        busy;

    logic        rx7 = 1'b1;
    logic        ready7 = 1'b0;
    logic        valid7;
    logic [6:0]  data7;
    logic        perr7;
    logic        ferr7;
    logic        ovr7;
    logic        busy7;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          frame_t0 = 0;
    int          rise_cyc = -1;
    int          valid_cycles = 0;
    int          ovr_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [9:0]  popq[$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(cpb),
        .i_Parity_En(par_en), .i_Parity_Odd(par_odd), .i_Two_Stop(two_stop),
        .i_Rx_Serial(rx), .o_Rx_Valid(rx_valid), .i_Rx_Ready(rx_ready),
        .o_Rx_Data(rx_data), .o_Parity_Err(perr), .o_Frame_Err(ferr),
        .o_Overrun(overrun), .o_Busy(busy)
    );

    uart_rx_param #(.DATA_WIDTH(7), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut7 (
        .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(cpb),
        .i_Parity_En(1'b1), .i_Parity_Odd(1'b1), .i_Two_Stop(1'b1),
        .i_Rx_Serial(rx7), .o_Rx_Valid(valid7), .i_Rx_Ready(ready7),
        .o_Rx_Data(data7), .o_Parity_Err(perr7), .o_Frame_Err(ferr7),
        .o_Overrun(ovr7), .o_Busy(busy7)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records every accepted entry and overrun pulse.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) popq.push_back({ferr, perr, rx_data});
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (rx_valid) begin
            valid_cycles = valid_cycles + 1;
            if (!prev_valid) rise_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    function automatic logic [9:0] qget(input int i);
        if (i < popq.size()) return popq[i];
        return 10'h3FF;
    endfunction

    task automatic set_line(input int sel, input logic b);
        if (sel == 1) rx7 = b;
        else rx = b;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit pb_en, input bit pb, input int nstop,
                              input bit stop_val, input int d);
        @(posedge clk); #1;
        frame_t0 = cyc;
        set_line(sel, 1'b0);
        repeat (d) @(posedge clk); #1;
        for (int i = 0; i < nbits; i++) begin
            set_line(sel, data[i]);
            repeat (d) @(posedge clk); #1;
        end
        if (pb_en) begin
            set_line(sel, pb);
            repeat (d) @(posedge clk); #1;
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(sel, (s == 0) ? stop_val : 1'b1);
            repeat (d) @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", rx_data); end
        n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b want 0", perr); end
        n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL rst_ferr: got %b want 0", ferr); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b want 0", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    endtask

    task automatic test_8n1;
        int vc0;
        rx_ready = 1'b1;
        popq.delete();
        vc0 = valid_cycles;
        send_frame(0, 9'h0A5, 8, 0, 0, 1, 1, 16);
        repeat (8) @(posedge clk); #1;
        // line low after P0 -> rx_s at P2 -> START at P3 -> stop sample cycle 152 -> written at P156
        n_checks++; if (rise_cyc !== frame_t0 + 156) begin n_fail++; $display("FAIL 8n1_latency: got %0d want %0d", rise_cyc, frame_t0 + 156); end
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL 8n1_count: got %0d want 1", popq.size()); end
        n_checks++; if (qget(0) !== 10'h0A5) begin n_fail++; $display("FAIL 8n1_entry: got %h want 0a5", qget(0)); end
        n_checks++; if (valid_cycles - vc0 !== 1) begin n_fail++; $display("FAIL 8n1_valid_cycles: got %0d want 1", valid_cycles - vc0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy: got %b want 0", busy); end
    endtask

    task automatic test_parity;
        rx_ready = 1'b1;
        par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0;
        popq.delete();
        // 0x37 has five ones: even parity bit must be 1
        send_frame(0, 9'h037, 8, 1, 0, 1, 1, 16);
        send_frame(0, 9'h037, 8, 1, 1, 1, 1, 16);
        repeat (8) @(posedge clk); #1;
        n_checks++; if (qget(0) !== {2'b01, 8'h37}) begin n_fail++; $display("FAIL par_bad: got %h want 137", qget(0)); end
        n_checks++; if (qget(1) !== {2'b00, 8'h37}) begin n_fail++; $display("FAIL par_good: got %h want 037", qget(1)); end
        par_en = 1'b0;
        // 7O2: 0x41 has two ones, odd parity bit is 1
        send_frame(1, 9'h041, 7, 1, 1, 2, 1, 16);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (valid7 !== 1'b1) begin n_fail++; $display("FAIL 7o2_valid: got %b want 1", valid7); end
        n_checks++; if (data7 !== 7'h41) begin n_fail++; $display("FAIL 7o2_data: got %h want 41", data7); end
        n_checks++; if ({ferr7, perr7} !== 2'b00) begin n_fail++; $display("FAIL 7o2_errs: got %b want 00", {ferr7, perr7}); end
        ready7 = 1'b1; @(posedge clk); #1; ready7 = 1'b0;
        send_frame(1, 9'h041, 7, 1, 0, 2, 1, 16);
        repeat (4) @(posedge clk); #1;
        n_checks++; if ({valid7, perr7, ferr7} !== 3'b110) begin n_fail++; $display("FAIL 7o2_bad_par: got %b want 110", {valid7, perr7, ferr7}); end
        ready7 = 1'b1; @(posedge clk); #1; ready7 = 1'b0;
        n_checks++; if ({valid7, busy7, ovr7} !== 3'b000) begin n_fail++; $display("FAIL 7o2_idle: got %b want 000", {valid7, busy7, ovr7}); end
    endtask

    task automatic test_break;
        rx_ready = 1'b1;
        popq.delete();
        send_frame(0, 9'h055, 8, 0, 0, 1, 0, 16);
        repeat (40 * 16) @(posedge clk); #1;
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL brk_count: got %0d want 1", popq.size()); end
        n_checks++; if (qget(0) !== {2'b10, 8'h55}) begin n_fail++; $display("FAIL brk_entry: got %h want 255", qget(0)); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL brk_wait_high: got %b want 1", busy); end
        rx = 1'b1;
        repeat (8) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL brk_release: got %b want 0", busy); end
        send_frame(0, 9'h03C, 8, 0, 0, 1, 1, 16);
        repeat (8) @(posedge clk); #1;
        n_checks++; if (qget(1) !== {2'b00, 8'h3C}) begin n_fail++; $display("FAIL brk_after: got %h want 03c", qget(1)); end
    endtask

    task automatic test_false_start;
        int vc0;
        rx_ready = 1'b1;
        popq.delete();
        vc0 = valid_cycles;
        @(posedge clk); #1; rx = 1'b0;
        repeat (3) @(posedge clk); #1; rx = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fs_started: got %b want 1", busy); end
        repeat (30) @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fs_idle: got %b want 0", busy); end
        n_checks++; if (valid_cycles - vc0 !== 0) begin n_fail++; $display("FAIL fs_valid: got %0d want 0", valid_cycles - vc0); end
    endtask

    task automatic test_overrun;
        int o0;
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 8, 0, 0, 1, 1, 16);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL ovr_early: got %0d want 0", ovr_cnt - o0); end
        n_checks++; if ({rx_valid, rx_data} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL ovr_head: got %h want 101", {rx_valid, rx_data}); end
        send_frame(0, 9'h005, 8, 0, 0, 1, 1, 16);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (ovr_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0); end
        popq.delete();
        rx_ready = 1'b1; repeat (8) @(posedge clk); #1; rx_ready = 1'b0;
        n_checks++; if (popq.size() !== 4) begin n_fail++; $display("FAIL ovr_drain_count: got %0d want 4", popq.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (qget(i) !== 10'(i + 1)) begin n_fail++; $display("FAIL ovr_drain_%0d: got %h want %h", i, qget(i), 10'(i + 1)); end
        end
        // Full FIFO with a pop in the push cycle: no overrun, all five kept.
        for (int i = 1; i <= 4; i++) send_frame(0, 9'(i), 8, 0, 0, 1, 1, 16);
        popq.delete();
        o0 = ovr_cnt;
        fork
            send_frame(0, 9'h005, 8, 0, 0, 1, 1, 16);
            begin
                @(posedge clk); #1;
                repeat (155) @(posedge clk); #1;
                rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
            end
        join
        repeat (4) @(posedge clk); #1;
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL ovr_simul_pop: got %0d want 0", ovr_cnt - o0); end
        rx_ready = 1'b1; repeat (8) @(posedge clk); #1; rx_ready = 1'b0;
        n_checks++; if (popq.size() !== 5) begin n_fail++; $display("FAIL ovr_simul_count: got %0d want 5", popq.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (qget(i) !== 10'(i + 1)) begin n_fail++; $display("FAIL ovr_simul_%0d: got %h want %h", i, qget(i), 10'(i + 1)); end
        end
    endtask

    task automatic test_reset_mid;
        rx_ready = 1'b0;
        send_frame(0, 9'h099, 8, 0, 0, 1, 1, 16);
        repeat (4) @(posedge clk); #1;
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got %b want 1", rx_valid); end
        fork
            send_frame(0, 9'h0F0, 8, 0, 0, 1, 1, 16);
            begin
                @(posedge clk); #1;
                repeat (70) @(posedge clk); #1;
                rst = 1'b1;
                #2;
                n_checks++; if ({rx_valid, rx_data, perr, ferr, overrun, busy} !== 13'd0) begin
                    n_fail++; $display("FAIL rm_outputs: got %h want 0", {rx_valid, rx_data, perr, ferr, overrun, busy});
                end
                repeat (15) @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        popq.delete();
        rx_ready = 1'b1;
        repeat (40) @(posedge clk); #1;
        n_checks++; if (popq.size() !== 0) begin n_fail++; $display("FAIL rm_no_push: got %0d want 0", popq.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    endtask

    task automatic test_config;
        rx_ready = 1'b1;
        popq.delete();
        fork
            send_frame(0, 9'h06B, 8, 0, 0, 1, 1, 16);
            begin
                @(posedge clk); #1;
                repeat (40) @(posedge clk); #1;
                cpb = 16'd32;
            end
        join
        repeat (8) @(posedge clk); #1;
        cpb = 16'd16;
        n_checks++; if (qget(0) !== 10'h06B) begin n_fail++; $display("FAIL cfg_midframe: got %h want 06b", qget(0)); end
        cpb = 16'd2;
        send_frame(0, 9'h0C3, 8, 0, 0, 1, 1, 4);
        repeat (8) @(posedge clk); #1;
        cpb = 16'd16;
        n_checks++; if (qget(1) !== 10'h0C3) begin n_fail++; $display("FAIL cfg_div_clamp: got %h want 0c3", qget(1)); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_break();
        test_false_start();
        test_overrun();
        test_reset_mid();
        test_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with a runtime baud divisor, configurable data width, optional even/odd parity, one or two stop bits, per-frame error flags and a small receive FIFO with a valid/ready output handshake. It sits between the serial pin and the byte-consuming logic that feeds the SHA core. It replaces the fixed 8N1 receiver, whose single-cycle strobe can lose data when the consumer is busy.

## Interface
- DATA_WIDTH, 8, data bits per frame, legal 5..9
- DIV_WIDTH, 16, width of the clocks-per-bit divisor
- FIFO_DEPTH, 4, receive FIFO entries, power of two, at least 2
- i_Clock  in  1  single clock domain
- i_Reset  in  1  asynchronous, active-high reset
- i_Clks_Per_Bit  in  DIV_WIDTH  bit period D in clocks; values below 4 are treated as 4
- i_Parity_En  in  1  1 = parity bit present after data
- i_Parity_Odd  in  1  1 = odd parity, 0 = even parity
- i_Two_Stop  in  1  1 = two stop bits
- i_Rx_Serial  in  1  asynchronous serial line, idle high
- o_Rx_Valid  out  1  FIFO non-empty
- i_Rx_Ready  in  1  consumer accepts head entry
- o_Rx_Data  out  DATA_WIDTH  head data, LSB = first received bit; 0 when o_Rx_Valid=0
- o_Parity_Err  out  1  head entry parity error; 0 when o_Rx_Valid=0
- o_Frame_Err  out  1  head entry stop-bit error; 0 when o_Rx_Valid=0
- o_Overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
- o_Busy  out  1  FSM is not in IDLE

## Operation
- Input synchroniser: two flops, both reset to 1. All FSM decisions use the second flop, called rx_s.
- Config capture: D, parity enable, parity mode and stop-bit count are latched on the IDLE to START transition. Changes to them mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: if rx_s=0, go to START with the counter cleared.
  - START: count up. When the counter equals D>>1, sample rx_s. If 0, go to DATA with the counter cleared. If 1, this is a false start: go to IDLE and push nothing.
  - DATA, PARITY, STOP1, STOP2: sample when the counter equals D-1, then clear the counter.
  - DATA: shift the sample into bit index i, LSB first. After DATA_WIDTH bits, go to PARITY if enabled, else STOP1.
  - PARITY: parity error if (XOR of data bits ^ parity bit ^ i_Parity_Odd latch) is 1.
  - STOP1: a 0 sample sets the frame error. Then go to STOP2 if two stop bits are configured, else to the end of frame.
  - STOP2: a 0 sample sets the frame error, then go to the end of frame.
- End of frame: in the cycle of the final stop sample, push {frame_err, parity_err, data} to the FIFO. Next state is IDLE if the final stop sample was 1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This stops a break or stuck-low line from being read as back-to-back frames.
- Frames with errors are pushed, flagged, not dropped.
- FIFO and handshake:
  - Pop occurs when o_Rx_Valid & i_Rx_Ready.
  - Push while full with no pop in the same cycle: the frame is discarded, o_Overrun pulses for 1 cycle, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push and pop in the same cycle while empty: the new entry is stored and o_Rx_Valid is 1 next cycle.
  - Pointers carry one extra wrap bit. Full means the pointers differ only in the MSB. Entries are delivered strictly in order.

## Timing
- Reset values:
  - o_Rx_Valid=0, o_Rx_Data=0, o_Parity_Err=0, o_Frame_Err=0, o_Overrun=0, o_Busy=0
  - FSM in IDLE, FIFO empty, synchroniser flops at 1
- Reset mid-frame aborts the frame. The partial frame is never pushed.
- rx_s follows i_Rx_Serial by 2 cycles. IDLE to START happens on the cycle after rx_s first reads 0.
- Sample points relative to START entry: cycle D>>1 for the start bit, then every D cycles for each following bit.
- For 8N1 with D=16: start sample at cycle 8, data samples at 24..136, stop sample at 152.
- o_Rx_Valid rises exactly 1 cycle after the push cycle, and the output fields are valid in that same cycle.
- o_Rx_Data and the error flags are combinational from the FIFO head and are stable while valid is high and ready is low.
- Throughput: the next frame's start bit may follow the stop bit immediately, because IDLE is re-entered at mid-stop-bit.

## Test plan
- 8N1, D=16, send 0xA5 with ready held 1 -> one valid cycle, data 0xA5, both error flags 0, o_Busy low after the stop sample.
- 8E1, D=16, send 0x37 with parity bit 0 (correct bit is 1) -> data 0x37, o_Parity_Err=1, o_Frame_Err=0. The same frame with parity bit 1 gives no error. 7O2 with 0x41 -> no error.
- Frame error and break: 8N1, byte 0x55 with the stop bit low, then the line held low for 40 bit times -> one entry with o_Frame_Err=1, no further entries, FSM in WAIT_HIGH until the line rises. A frame sent afterwards is received cleanly.
- False start: a low glitch of 3 clocks with D=16 -> FSM returns to IDLE, nothing pushed, o_Rx_Valid stays 0.
- Overrun: FIFO_DEPTH=4, ready held 0, send 0x01..0x05 -> o_Overrun pulses once at frame 5's stop sample. Draining then yields 0x01..0x04 in order. Separately, full FIFO with ready=1 in the push cycle -> no overrun.
- Reset and config: assert i_Reset during data bit 3 -> all outputs 0, no entry pushed. Change i_Clks_Per_Bit from 16 to 32 mid-frame -> the frame still decodes correctly at D=16. D=2 programmed -> behaves as D=4.
